// File: rtl/ringbuf_mp.sv
// Multi-port ring buffer: up to WPORTS pushes and RPORTS retires per clock,
// all-or-nothing group legality, one-cycle error pulse, synchronous flush.
module ringbuf_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int WPORTS = 2,
  parameter int RPORTS = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  input  logic                     i_flush,
  input  logic [WPORTS-1:0]        i_we,
  input  logic [WPORTS*WIDTH-1:0]  i_data,
  input  logic [RPORTS-1:0]        i_re,
  output logic [RPORTS*WIDTH-1:0]  o_data,
  output logic [RPORTS-1:0]        o_valid,
  output logic [CW-1:0]            o_count,
  output logic [CW-1:0]            o_free,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             err;

  logic [CW-1:0]     nw;
  logic [CW-1:0]     nr;
  logic [CW-1:0]     free_cnt;
  logic [WPORTS-1:0] we_inc;
  logic [RPORTS-1:0] re_inc;
  logic              we_therm;
  logic              re_therm;
  logic              wr_ok;
  logic              rd_ok;

  // Lane handshake: o_valid[k] means an entry sits at head+k; a read group
  // i_re is accepted only when every requested lane is valid and the mask is a
  // thermometer from lane 0. Writes likewise need thermometer mask and room.
  always_comb begin
    nw = '0;
    nr = '0;
    for (int k = 0; k < WPORTS; k++) nw = nw + CW'(i_we[k]);
    for (int k = 0; k < RPORTS; k++) nr = nr + CW'(i_re[k]);
    we_inc   = i_we + WPORTS'(1);
    re_inc   = i_re + RPORTS'(1);
    we_therm = ((i_we & we_inc) == '0);
    re_therm = ((i_re & re_inc) == '0);
    free_cnt = CW'(DEPTH) - count;
    wr_ok    = we_therm && (nw <= free_cnt);
    rd_ok    = re_therm && (nr <= count);
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      // Write slots are free and read slots are occupied, so they never collide.
      for (int k = 0; k < WPORTS; k++)
        if (wr_ok && i_we[k]) mem[tail + AW'(k)] <= i_data[k*WIDTH +: WIDTH];
      for (int k = 0; k < RPORTS; k++)
        if (rd_ok && i_re[k]) mem[head + AW'(k)] <= '0;
      if (wr_ok) tail <= tail + AW'(nw);
      if (rd_ok) head <= head + AW'(nr);
      count <= count + (wr_ok ? nw : '0) - (rd_ok ? nr : '0);
      err   <= !(wr_ok && rd_ok);
    end
  end

  always_comb begin
    o_data  = '0;
    o_valid = '0;
    for (int k = 0; k < RPORTS; k++) begin
      if (count > CW'(k)) begin
        o_valid[k]               = 1'b1;
        o_data[k*WIDTH +: WIDTH] = mem[head + AW'(k)];
      end
    end
  end

  assign o_count = count;
  assign o_free  = free_cnt;
  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));
  assign o_err   = err;

endmodule

// File: tb/tb_ringbuf_mp.sv
// Bench for ringbuf_mp: directed scenarios then random traffic, checked
// against a queue model of the buffer contents.
module tb_ringbuf_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int WP    = 2;
  localparam int RP    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 i_clk;
  logic                 i_srst;
  logic                 i_flush;
  logic [WP-1:0]        i_we;
  logic [WP*WIDTH-1:0]  i_data;
  logic [RP-1:0]        i_re;
  logic [RP*WIDTH-1:0]  o_data;
  logic [RP-1:0]        o_valid;
  logic [CW-1:0]        o_count;
  logic [CW-1:0]        o_free;
  logic                 o_empty;
  logic                 o_full;
  logic                 o_err;

  ringbuf_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WPORTS(WP), .RPORTS(RP)) dut (
    .i_clk(i_clk), .i_srst(i_srst), .i_flush(i_flush), .i_we(i_we),
    .i_data(i_data), .i_re(i_re), .o_data(o_data), .o_valid(o_valid),
    .o_count(o_count), .o_free(o_free), .o_empty(o_empty), .o_full(o_full),
    .o_err(o_err)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_therm(input logic [1:0] m);
    return (m == 2'b00) || (m == 2'b01) || (m == 2'b11);
  endfunction

  function automatic int popc(input logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  // driver: one clock of stimulus, scoreboard update, and post-edge checks
  task automatic step(input bit srst, input bit flush, input logic [1:0] we,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] re);
    int nw;
    int nr;
    bit wl;
    bit rl;
    logic [31:0] exp_d;
    @(negedge i_clk);
    i_srst  = srst;
    i_flush = flush;
    i_we    = we;
    i_data  = {d1, d0};
    i_re    = re;
    #1;
    for (int k = 0; k < RP; k++) begin
      exp_d = 32'h0;
      if (exp_q.size() > k) exp_d = exp_q[k];
      check($sformatf("valid%0d", k), {31'b0, o_valid[k]}, {31'b0, exp_q.size() > k});
      check($sformatf("data%0d", k), o_data[k*WIDTH +: WIDTH], exp_d);
    end
    if (srst || flush) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      nw = popc(we);
      nr = popc(re);
      wl = is_therm(we) && (nw <= DEPTH - exp_q.size());
      rl = is_therm(re) && (nr <= exp_q.size());
      if (rl) repeat (nr) void'(exp_q.pop_front());
      if (wl) begin
        if (nw > 0) exp_q.push_back(d0);
        if (nw > 1) exp_q.push_back(d1);
      end
      exp_err = !(wl && rl);
    end
    @(posedge i_clk);
    #1;
    check("count", 32'(o_count), 32'(exp_q.size()));
    check("free",  32'(o_free),  32'(DEPTH - exp_q.size()));
    check("empty", {31'b0, o_empty}, {31'b0, exp_q.size() == 0});
    check("full",  {31'b0, o_full},  {31'b0, exp_q.size() == DEPTH});
    check("err",   {31'b0, o_err},   {31'b0, exp_err});
  endtask

  task automatic wr(input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1);
    step(1'b0, 1'b0, we, d0, d1, 2'b00);
  endtask

  task automatic rd(input logic [1:0] re);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, re);
  endtask

  initial begin
    i_srst = 1'b1; i_flush = 1'b0; i_we = '0; i_re = '0; i_data = '0;
    step(1'b1, 1'b0, 2'b00, 0, 0, 2'b00);
    step(1'b1, 1'b0, 2'b11, 32'hEE, 32'hEF, 2'b11);

    // two-lane burst to full
    repeat (8) wr(2'b11, 32'hA0, 32'hA1);
    rd(2'b01);                                  // 15 left
    wr(2'b11, 32'hB0, 32'hB1);                  // overflow, rejected
    wr(2'b01, 32'hC0, 32'h0);                   // 16
    step(1'b0, 1'b0, 2'b11, 32'hD0, 32'hD1, 2'b11); // read ok, write rejected
    repeat (6) rd(2'b11);                       // 2
    rd(2'b01);                                  // 1
    rd(2'b11);                                  // underflow
    wr(2'b10, 32'hE0, 32'hE1);                  // illegal mask
    rd(2'b01);                                  // 0
    rd(2'b01);                                  // empty read

    // wrap-around with concurrent traffic
    for (int i = 0; i < 7; i++) wr(2'b11, 32'h100 + 2*i, 32'h101 + 2*i);
    wr(2'b01, 32'h1FE, 32'h0);                  // 15
    repeat (7) rd(2'b11);                       // 1
    wr(2'b11, 32'h200, 32'h201);                // 3
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 2'b11, 32'h300 + 2*i, 32'h301 + 2*i, 2'b11);
    wr(2'b11, 32'h400, 32'h401);
    wr(2'b11, 32'h402, 32'h403);
    wr(2'b01, 32'h404, 32'h0);                  // 8
    step(1'b0, 1'b0, 2'b11, 32'h500, 32'h501, 2'b11); // stays 8

    // error pulse cleared by flush, flush ignores pending writes
    rd(2'b10);
    step(1'b0, 1'b1, 2'b11, 32'h600, 32'h601, 2'b00);
    rd(2'b00);

    // mid-burst reset, first write afterwards lands on lane 0
    repeat (3) wr(2'b11, 32'h700, 32'h701);
    step(1'b1, 1'b0, 2'b11, 32'h710, 32'h711, 2'b01);
    wr(2'b01, 32'h55, 32'h0);
    rd(2'b00);

    // random traffic including illegal masks and occasional flush
    repeat (400) begin
      step(1'b0, ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
           $urandom, $urandom, 2'($urandom_range(0, 3)));
    end
    rd(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
